// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA timing definitions.
// Holds the 800x600@60 (40 MHz pixel clock) default timing constants, the
// common counter width used by every block that handles pixel coordinates,
// and a small window-decode helper.
package vga_pkg;

  // Width of pixel/line coordinates throughout the display pipeline.
  localparam int unsigned CNT_W = 11;

  // Horizontal timing, in pixels.
  localparam int unsigned DEF_H_VISIBLE = 800;
  localparam int unsigned DEF_H_FP      = 40;
  localparam int unsigned DEF_H_SYNC    = 128;
  localparam int unsigned DEF_H_BP      = 88;

  // Vertical timing, in lines.
  localparam int unsigned DEF_V_VISIBLE = 600;
  localparam int unsigned DEF_V_FP      = 1;
  localparam int unsigned DEF_V_SYNC    = 4;
  localparam int unsigned DEF_V_BP      = 23;

  // True when lo <= cnt < hi (half-open window).
  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// mod_counter -- modulo-N up counter with enable.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (priority over en)
//   en         : count enable
//   count      : registered count, 0..N-1
//   count_next : value count takes at the next edge (lets the parent decode
//                registered outputs that line up with count)
//   wrap       : high in an enabled cycle where count goes N-1 -> 0
module mod_counter #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next-count and wrap decode.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (rst) begin
      count_d = '0;
      wrap    = 1'b0;
    end else if (en) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + W'(1);
        wrap    = 1'b0;
      end
    end else begin
      count_d = count_q;
      wrap    = 1'b0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
// Produces pixel/line coordinates and sync/blanking strobes for a display
// pipeline. All outputs are registered and mutually aligned: the strobes are
// decoded from the counters' next values so they refer to the same (hcount,
// vcount) that is presented in the same cycle.
// Ports:
//   pclk        : pixel clock
//   rst         : synchronous active-high reset, wins over en
//   en          : count enable; low freezes every output
//   hcount      : current pixel column
//   vcount      : current line
//   hsync/vsync : sync strobes, at SYNC_POL inside their windows
//   hblnk/vblnk : high outside the visible columns / lines
//   frame_start : one-cycle pulse when the raster wraps to (0,0)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter logic        SYNC_POL  = 1'b1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_en;

  // The line counter advances only on the pixel that ends a line.
  assign v_en = en & h_wrap;

  mod_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk        (pclk),
    .rst        (rst),
    .en         (en),
    .count      (hcount),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  mod_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk        (pclk),
    .rst        (rst),
    .en         (v_en),
    .count      (vcount),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  logic hsync_d, hsync_q;
  logic vsync_d, vsync_q;
  logic hblnk_d, hblnk_q;
  logic vblnk_d, vblnk_q;
  logic frame_start_d, frame_start_q;

  // Strobe decode from next-state counts; hold everything while stalled.
  always_comb begin
    hsync_d       = ~SYNC_POL;
    vsync_d       = ~SYNC_POL;
    hblnk_d       = 1'b0;
    vblnk_d       = 1'b0;
    frame_start_d = 1'b0;
    if (rst) begin
      hsync_d       = ~SYNC_POL;
      vsync_d       = ~SYNC_POL;
      hblnk_d       = 1'b0;
      vblnk_d       = 1'b0;
      frame_start_d = 1'b0;
    end else if (en) begin
      hsync_d       = in_window(h_next, H_SYNC_BEG, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      vsync_d       = in_window(v_next, V_SYNC_BEG, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
      hblnk_d       = (h_next >= H_VIS_END);
      vblnk_d       = (v_next >= V_VIS_END);
      // Both axes wrapping together is exactly the move to (0,0).
      frame_start_d = h_wrap & v_wrap;
    end else begin
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      hblnk_d       = hblnk_q;
      vblnk_d       = vblnk_q;
      frame_start_d = frame_start_q;
    end
  end

  // Output strobe registers.
  always_ff @(posedge pclk) begin
    hsync_q       <= hsync_d;
    vsync_q       <= vsync_d;
    hblnk_q       <= hblnk_d;
    vblnk_q       <= vblnk_d;
    frame_start_q <= frame_start_d;
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. A reference model tracks the linear
// pixel index within the frame and derives coordinates and strobes from it
// arithmetically. Three DUTs run from the same stimulus: a small raster with
// active-high sync, the same raster with active-low sync, and the default
// 800x600 timing (used for one-line checks).
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } out_t;

  typedef struct packed {
    out_t a;
    out_t b;
    out_t c;
  } exp_t;

  // Small raster: 32 x 20 total, 640 pixels per frame.
  localparam int SHV = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVV = 10, SVF = 2, SVS = 3, SVB = 5;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SFT = SHT * (SVV + SVF + SVS + SVB);
  // Default raster.
  localparam int DHT = 1056;
  localparam int DFT = 1056 * 628;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic en   = 1'b0;

  out_t got_a, got_b, got_c;

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)
  ) dut_a (
    .pclk(pclk), .rst(rst), .en(en),
    .hcount(got_a.h), .vcount(got_a.v), .hsync(got_a.hs), .vsync(got_a.vs),
    .hblnk(got_a.hb), .vblnk(got_a.vb), .frame_start(got_a.fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b0)
  ) dut_b (
    .pclk(pclk), .rst(rst), .en(en),
    .hcount(got_b.h), .vcount(got_b.v), .hsync(got_b.hs), .vsync(got_b.vs),
    .hblnk(got_b.hb), .vblnk(got_b.vb), .frame_start(got_b.fs)
  );

  vga_timing_gen dut_c (
    .pclk(pclk), .rst(rst), .en(en),
    .hcount(got_c.h), .vcount(got_c.v), .hsync(got_c.hs), .vsync(got_c.vs),
    .hblnk(got_c.hb), .vblnk(got_c.vb), .frame_start(got_c.fs)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  // Model state per raster: pixel index in frame and frame_start flag.
  int p_s = 0, p_d = 0;
  bit fs_s = 1'b0, fs_d = 1'b0;
  int exp_fs_pulses = 0, got_fs_pulses = 0;
  bit prev_exp_fs = 1'b0, prev_got_fs = 1'b0;

  function automatic out_t ref_out(int p, bit fs, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, bit pol);
    out_t o;
    int ht, h, v;
    ht   = hv + hf + hs + hb;
    h    = p % ht;
    v    = p / ht;
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hb = (h >= hv);
    o.vb = (v >= vv);
    o.hs = (h >= hv + hf && h < hv + hf + hs) ? pol : ~pol;
    o.vs = (v >= vv + vf && v < vv + vf + vs) ? pol : ~pol;
    o.fs = fs;
    return o;
  endfunction

  task automatic model_adv(inout int p, inout bit fs, input bit r, input bit e, input int ft);
    if (r) begin
      p  = 0;
      fs = 1'b0;
    end else if (e) begin
      p  = (p + 1) % ft;
      fs = (p == 0);
    end
  endtask

  // One clock: apply (r,e), advance model at the edge, queue the expectation.
  task automatic step(input bit r, input bit e);
    exp_t x;
    rst = r;
    en  = e;
    @(posedge pclk);
    model_adv(p_s, fs_s, r, e, SFT);
    model_adv(p_d, fs_d, r, e, DFT);
    x.a = ref_out(p_s, fs_s, SHV, SHF, SHS, SHB, SVV, SVF, SVS, 1'b1);
    x.b = ref_out(p_s, fs_s, SHV, SHF, SHS, SHB, SVV, SVF, SVS, 1'b0);
    x.c = ref_out(p_d, fs_d, 800, 40, 128, 88, 600, 1, 4, 1'b1);
    if (fs_s && !prev_exp_fs) exp_fs_pulses++;
    prev_exp_fs = fs_s;
    sb.push_back(x);
    #1;
  endtask

  task automatic cmp(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b required h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b",
               name, $time, got.h, got.v, got.hs, got.vs, got.hb, got.vb, got.fs,
               exp.h, exp.v, exp.hs, exp.vs, exp.hb, exp.vb, exp.fs);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare on the falling edge.
  initial begin : monitor
    exp_t x;
    int budget;
    budget = 0;
    while ((!stim_done || sb.size() > 0) && budget < 20000) begin
      @(negedge pclk);
      budget++;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        cmp("small_pos", got_a, x.a);
        cmp("small_neg", got_b, x.b);
        cmp("default",   got_c, x.c);
        if (got_a.fs === 1'b1 && !prev_got_fs) got_fs_pulses++;
        prev_got_fs = (got_a.fs === 1'b1);
      end
    end
    checks++;
    if (sb.size() != 0 || !stim_done) begin
      errors++;
      $display("FAIL monitor_timeout pending=%0d done=%0b required pending=0 done=1",
               sb.size(), stim_done);
    end
    checks++;
    if (got_fs_pulses != exp_fs_pulses) begin
      errors++;
      $display("FAIL frame_start_count got %0d required %0d", got_fs_pulses, exp_fs_pulses);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Stimulus: directed phases followed by randomized en/rst traffic.
  initial begin : stimulus
    int guard;
    // Reset held 5 cycles with en high.
    repeat (5) step(1'b1, 1'b1);
    // Two small frames; also more than one full default line.
    repeat (2 * SFT + 10) step(1'b0, 1'b1);
    // Stall on the last pixel of the small frame, then resume into (0,0).
    guard = 0;
    while (p_s != SFT - 1 && guard < SFT + 1) begin
      step(1'b0, 1'b1);
      guard++;
    end
    repeat (10) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b1);
    // Mid-frame reset at small (h=10, v=5).
    guard = 0;
    while (p_s != 5 * SHT + 10 && guard < SFT + 1) begin
      step(1'b0, 1'b1);
      guard++;
    end
    step(1'b1, 1'b1);
    repeat (SFT + 5) step(1'b0, 1'b1);
    // Randomized enable stalls and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0));
    end
    rst = 1'b0;
    en  = 1'b0;
    stim_done = 1'b1;
  end

endmodule
